// File: rtl/pipe_hazard_ctrl_if.sv
// Control bundle between the pipeline datapath and the hazard sequencer.
// The datapath side is master; the sequencer is slave.
interface pipe_hazard_ctrl_if #(
  parameter int CNT_W = 32
);
  logic             id_valid_i;
  logic [4:0]       id_rs1_addr_i;
  logic [4:0]       id_rs2_addr_i;
  logic             id_rs1_use_i;
  logic             id_rs2_use_i;
  logic [4:0]       ex_rd_addr_i;
  logic             ex_regwen_i;
  logic             ex_memrd_i;
  logic             ex_mispredict_i;
  logic             mem_busy_i;
  logic             pc_en_o;
  logic             redirect_o;
  logic             ifid_en_o;
  logic             ifid_nop_o;
  logic             idex_en_o;
  logic             idex_nop_o;
  logic             exmem_en_o;
  logic [1:0]       state_o;
  logic [CNT_W-1:0] stall_cnt_o;
  logic [CNT_W-1:0] flush_cnt_o;

  modport master (
    output id_valid_i, id_rs1_addr_i, id_rs2_addr_i, id_rs1_use_i, id_rs2_use_i,
           ex_rd_addr_i, ex_regwen_i, ex_memrd_i, ex_mispredict_i, mem_busy_i,
    input  pc_en_o, redirect_o, ifid_en_o, ifid_nop_o, idex_en_o, idex_nop_o,
           exmem_en_o, state_o, stall_cnt_o, flush_cnt_o
  );

  modport slave (
    input  id_valid_i, id_rs1_addr_i, id_rs2_addr_i, id_rs1_use_i, id_rs2_use_i,
           ex_rd_addr_i, ex_regwen_i, ex_memrd_i, ex_mispredict_i, mem_busy_i,
    output pc_en_o, redirect_o, ifid_en_o, ifid_nop_o, idex_en_o, idex_nop_o,
           exmem_en_o, state_o, stall_cnt_o, flush_cnt_o
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use bubbles, EX mispredict
// flushes, data-memory freezes, and saturating stall/flush counters.
module pipe_hazard_ctrl #(
  parameter int LD_LAT = 1,
  parameter int CNT_W  = 32
) (
  input logic               clk_i,
  input logic               rst_ni,
  pipe_hazard_ctrl_if.slave bus
);
  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_LDSTALL = 2'd1,
    ST_MEMWAIT = 2'd2
  } state_t;

  localparam logic [3:0] LD_INIT = 4'(LD_LAT - 1);

  state_t           state_reg, state_next;
  logic [3:0]       ld_cnt_reg, ld_cnt_next;
  logic [CNT_W-1:0] stall_cnt_reg, flush_cnt_reg;

  logic pc_en, redirect, ifid_en, ifid_nop, idex_en, idex_nop, exmem_en;
  logic run_eval;
  logic load_use;

  logic [4:0] src_addr [2];
  logic [1:0] src_use;
  logic [1:0] src_hit;

  assign src_addr[0] = bus.id_rs1_addr_i;
  assign src_addr[1] = bus.id_rs2_addr_i;
  assign src_use     = {bus.id_rs2_use_i, bus.id_rs1_use_i};

  for (genvar gi = 0; gi < 2; gi++) begin : g_src
    assign src_hit[gi] = src_use[gi] && (src_addr[gi] == bus.ex_rd_addr_i);
  end

  assign load_use = bus.id_valid_i && bus.ex_memrd_i && bus.ex_regwen_i &&
                    (bus.ex_rd_addr_i != 5'd0) && (|src_hit);

  always_comb begin
    state_next  = state_reg;
    ld_cnt_next = ld_cnt_reg;
    pc_en       = 1'b1;
    redirect    = 1'b0;
    ifid_en     = 1'b1;
    ifid_nop    = 1'b0;
    idex_en     = 1'b1;
    idex_nop    = 1'b0;
    exmem_en    = 1'b1;
    run_eval    = 1'b0;

    case (state_reg)
      ST_RUN: run_eval = 1'b1;
      ST_LDSTALL: begin
        pc_en   = 1'b0;
        ifid_en = 1'b0;
        if (bus.mem_busy_i) begin
          idex_en  = 1'b0;
          exmem_en = 1'b0;
        end else begin
          idex_nop = 1'b1;
          if (ld_cnt_reg <= 4'd1) begin
            state_next  = ST_RUN;
            ld_cnt_next = 4'd0;
          end else begin
            ld_cnt_next = ld_cnt_reg - 4'd1;
          end
        end
      end
      ST_MEMWAIT: begin
        // The cycle busy drops is decided exactly as a RUN cycle would be.
        if (bus.mem_busy_i) begin
          pc_en    = 1'b0;
          ifid_en  = 1'b0;
          idex_en  = 1'b0;
          exmem_en = 1'b0;
        end else begin
          run_eval = 1'b1;
        end
      end
      default: state_next = ST_RUN;
    endcase

    if (run_eval) begin
      state_next = ST_RUN;
      if (bus.mem_busy_i) begin
        pc_en      = 1'b0;
        ifid_en    = 1'b0;
        idex_en    = 1'b0;
        exmem_en   = 1'b0;
        state_next = ST_MEMWAIT;
      end else if (bus.ex_mispredict_i) begin
        redirect = 1'b1;
        ifid_nop = 1'b1;
        idex_nop = 1'b1;
      end else if (load_use) begin
        pc_en    = 1'b0;
        ifid_en  = 1'b0;
        idex_nop = 1'b1;
        if (LD_LAT > 1) begin
          state_next  = ST_LDSTALL;
          ld_cnt_next = LD_INIT;
        end
      end
    end

    if (!rst_ni) begin
      pc_en       = 1'b0;
      redirect    = 1'b0;
      ifid_en     = 1'b0;
      ifid_nop    = 1'b1;
      idex_en     = 1'b0;
      idex_nop    = 1'b1;
      exmem_en    = 1'b0;
      state_next  = ST_RUN;
      ld_cnt_next = 4'd0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_reg     <= ST_RUN;
      ld_cnt_reg    <= 4'd0;
      stall_cnt_reg <= '0;
      flush_cnt_reg <= '0;
    end else begin
      state_reg  <= state_next;
      ld_cnt_reg <= ld_cnt_next;
      if (!pc_en && (stall_cnt_reg != '1)) begin
        stall_cnt_reg <= stall_cnt_reg + CNT_W'(1);
      end
      if (redirect && (flush_cnt_reg != '1)) begin
        flush_cnt_reg <= flush_cnt_reg + CNT_W'(1);
      end
    end
  end

  assign bus.pc_en_o     = pc_en;
  assign bus.redirect_o  = redirect;
  assign bus.ifid_en_o   = ifid_en;
  assign bus.ifid_nop_o  = ifid_nop;
  assign bus.idex_en_o   = idex_en;
  assign bus.idex_nop_o  = idex_nop;
  assign bus.exmem_en_o  = exmem_en;
  assign bus.state_o     = state_reg;
  assign bus.stall_cnt_o = stall_cnt_reg;
  assign bus.flush_cnt_o = flush_cnt_reg;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: three instances (LD_LAT=1, LD_LAT=3, 4-bit
// counters) share one stimulus stream; each check targets the relevant instance.
module tb_pipe_hazard_ctrl;
  typedef struct packed {
    logic       rst_n;
    logic       valid;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       rs1_use;
    logic       rs2_use;
    logic [4:0] ex_rd;
    logic       regwen;
    logic       memrd;
    logic       mispred;
    logic       busy;
  } in_t;

  typedef struct {
    in_t        in;
    logic [6:0] ctl;
    logic [1:0] st;
  } vec_t;

  // Control word order: {pc_en, redirect, ifid_en, ifid_nop, idex_en, idex_nop, exmem_en}
  localparam logic [6:0] C_DEF    = 7'b1010101;
  localparam logic [6:0] C_STALL  = 7'b0000111;
  localparam logic [6:0] C_FLUSH  = 7'b1111111;
  localparam logic [6:0] C_FREEZE = 7'b0000000;
  localparam logic [6:0] C_RST    = 7'b0001010;

  logic clk_i;
  in_t  stim;
  logic rst_n;
  int   n_checks = 0;
  int   n_err    = 0;

  pipe_hazard_ctrl_if #(.CNT_W(32)) if1 ();
  pipe_hazard_ctrl_if #(.CNT_W(32)) if3 ();
  pipe_hazard_ctrl_if #(.CNT_W(4))  ifs ();

  pipe_hazard_ctrl #(.LD_LAT(1), .CNT_W(32)) u_lat1 (.clk_i(clk_i), .rst_ni(rst_n), .bus(if1));
  pipe_hazard_ctrl #(.LD_LAT(3), .CNT_W(32)) u_lat3 (.clk_i(clk_i), .rst_ni(rst_n), .bus(if3));
  pipe_hazard_ctrl #(.LD_LAT(1), .CNT_W(4))  u_sat  (.clk_i(clk_i), .rst_ni(rst_n), .bus(ifs));

  assign rst_n = stim.rst_n;

  assign if1.id_valid_i = stim.valid;   assign if3.id_valid_i = stim.valid;   assign ifs.id_valid_i = stim.valid;
  assign if1.id_rs1_addr_i = stim.rs1;  assign if3.id_rs1_addr_i = stim.rs1;  assign ifs.id_rs1_addr_i = stim.rs1;
  assign if1.id_rs2_addr_i = stim.rs2;  assign if3.id_rs2_addr_i = stim.rs2;  assign ifs.id_rs2_addr_i = stim.rs2;
  assign if1.id_rs1_use_i = stim.rs1_use; assign if3.id_rs1_use_i = stim.rs1_use; assign ifs.id_rs1_use_i = stim.rs1_use;
  assign if1.id_rs2_use_i = stim.rs2_use; assign if3.id_rs2_use_i = stim.rs2_use; assign ifs.id_rs2_use_i = stim.rs2_use;
  assign if1.ex_rd_addr_i = stim.ex_rd; assign if3.ex_rd_addr_i = stim.ex_rd; assign ifs.ex_rd_addr_i = stim.ex_rd;
  assign if1.ex_regwen_i = stim.regwen; assign if3.ex_regwen_i = stim.regwen; assign ifs.ex_regwen_i = stim.regwen;
  assign if1.ex_memrd_i = stim.memrd;   assign if3.ex_memrd_i = stim.memrd;   assign ifs.ex_memrd_i = stim.memrd;
  assign if1.ex_mispredict_i = stim.mispred; assign if3.ex_mispredict_i = stim.mispred; assign ifs.ex_mispredict_i = stim.mispred;
  assign if1.mem_busy_i = stim.busy;    assign if3.mem_busy_i = stim.busy;    assign ifs.mem_busy_i = stim.busy;

  logic [6:0] ctl1, ctl3;
  assign ctl1 = {if1.pc_en_o, if1.redirect_o, if1.ifid_en_o, if1.ifid_nop_o,
                 if1.idex_en_o, if1.idex_nop_o, if1.exmem_en_o};
  assign ctl3 = {if3.pc_en_o, if3.redirect_o, if3.ifid_en_o, if3.ifid_nop_o,
                 if3.idex_en_o, if3.idex_nop_o, if3.exmem_en_o};

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  function automatic in_t mk(input logic v, input logic [4:0] r1, input logic [4:0] r2,
                             input logic u1, input logic u2, input logic [4:0] rd,
                             input logic w, input logic ld, input logic mis, input logic busy);
    in_t t;
    t.rst_n = 1'b1; t.valid = v; t.rs1 = r1; t.rs2 = r2; t.rs1_use = u1; t.rs2_use = u2;
    t.ex_rd = rd; t.regwen = w; t.memrd = ld; t.mispred = mis; t.busy = busy;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%0h", name, act);
    end
  endtask

  // Inputs change just after the rising edge; outputs are sampled on the falling edge.
  task automatic drive(input in_t v);
    @(posedge clk_i);
    #1 stim = v;
    @(negedge clk_i);
  endtask

  in_t  idle_v, rst_v, lu3_v, busy_v, mis_v, bm_v;
  vec_t tbl [13];

  task automatic do_reset();
    drive(rst_v);
    drive(idle_v);
  endtask

  initial begin
    idle_v = mk(1, 5'd1, 5'd2, 1, 1, 5'd3, 1, 0, 0, 0);
    rst_v  = mk(1, 5'd9, 5'd9, 1, 1, 5'd9, 1, 1, 1, 1);
    rst_v.rst_n = 1'b0;
    lu3_v  = mk(1, 5'd4, 5'd5, 1, 1, 5'd5, 1, 1, 0, 0);
    busy_v = idle_v; busy_v.busy = 1'b1;
    mis_v  = idle_v; mis_v.mispred = 1'b1;
    bm_v   = busy_v; bm_v.mispred = 1'b1;

    tbl[0]  = '{in: idle_v,                                      ctl: C_DEF,    st: 2'd0};
    tbl[1]  = '{in: mk(1, 5'd4, 5'd5, 0, 1, 5'd5, 1, 1, 0, 0),    ctl: C_STALL,  st: 2'd0};
    tbl[2]  = '{in: idle_v,                                      ctl: C_DEF,    st: 2'd0};
    tbl[3]  = '{in: mk(1, 5'd0, 5'd0, 1, 1, 5'd0, 1, 1, 0, 0),    ctl: C_DEF,    st: 2'd0};
    tbl[4]  = '{in: mk(1, 5'd7, 5'd2, 0, 1, 5'd7, 1, 1, 0, 0),    ctl: C_DEF,    st: 2'd0};
    tbl[5]  = '{in: mk(0, 5'd5, 5'd5, 1, 1, 5'd5, 1, 1, 0, 0),    ctl: C_DEF,    st: 2'd0};
    tbl[6]  = '{in: mk(1, 5'd5, 5'd5, 1, 1, 5'd5, 0, 1, 0, 0),    ctl: C_DEF,    st: 2'd0};
    tbl[7]  = '{in: mk(1, 5'd5, 5'd5, 1, 1, 5'd5, 1, 0, 0, 0),    ctl: C_DEF,    st: 2'd0};
    tbl[8]  = '{in: mk(1, 5'd9, 5'd2, 1, 0, 5'd9, 1, 1, 0, 0),    ctl: C_STALL,  st: 2'd0};
    tbl[9]  = '{in: mk(1, 5'd9, 5'd9, 1, 1, 5'd9, 1, 1, 1, 0),    ctl: C_FLUSH,  st: 2'd0};
    tbl[10] = '{in: mk(1, 5'd9, 5'd9, 1, 1, 5'd9, 1, 1, 1, 1),    ctl: C_FREEZE, st: 2'd0};
    tbl[11] = '{in: idle_v,                                      ctl: C_DEF,    st: 2'd2};
    tbl[12] = '{in: idle_v,                                      ctl: C_DEF,    st: 2'd0};

    stim = rst_v;

    // Reset held with busy and mispredict asserted
    for (int c = 0; c < 3; c++) begin
      drive(rst_v);
      chk($sformatf("reset[%0d] ctl lat1", c), 32'(ctl1), 32'(C_RST));
      chk($sformatf("reset[%0d] ctl lat3", c), 32'(ctl3), 32'(C_RST));
    end
    chk("reset state", 32'(if1.state_o), 32'd0);
    chk("reset stall_cnt", if1.stall_cnt_o, 32'd0);
    chk("reset flush_cnt", if1.flush_cnt_o, 32'd0);
    drive(idle_v);
    chk("release ctl", 32'(ctl1), 32'(C_DEF));
    chk("release state", 32'(if1.state_o), 32'd0);

    // Single-cycle decisions on the LD_LAT=1 instance
    for (int i = 0; i < 13; i++) begin
      drive(tbl[i].in);
      chk($sformatf("tbl[%0d] ctl", i), 32'(ctl1), 32'(tbl[i].ctl));
      chk($sformatf("tbl[%0d] state", i), 32'(if1.state_o), 32'(tbl[i].st));
    end
    drive(idle_v);
    chk("tbl stall_cnt", if1.stall_cnt_o, 32'd3);
    chk("tbl flush_cnt", if1.flush_cnt_o, 32'd1);

    // LD_LAT=3: three bubbles, then three bubbles stretched by two busy cycles
    do_reset();
    drive(lu3_v);  chk("lat3 b0 ctl", 32'(ctl3), 32'(C_STALL)); chk("lat3 b0 st", 32'(if3.state_o), 32'd0);
    drive(idle_v); chk("lat3 b1 ctl", 32'(ctl3), 32'(C_STALL)); chk("lat3 b1 st", 32'(if3.state_o), 32'd1);
    drive(idle_v); chk("lat3 b2 ctl", 32'(ctl3), 32'(C_STALL)); chk("lat3 b2 st", 32'(if3.state_o), 32'd1);
    drive(idle_v); chk("lat3 done ctl", 32'(ctl3), 32'(C_DEF)); chk("lat3 done st", 32'(if3.state_o), 32'd0);
    drive(idle_v); chk("lat3 stall_cnt", if3.stall_cnt_o, 32'd3);
    drive(lu3_v);  chk("lat3b b0 ctl", 32'(ctl3), 32'(C_STALL));
    drive(busy_v); chk("lat3b busy0 ctl", 32'(ctl3), 32'(C_FREEZE)); chk("lat3b busy0 st", 32'(if3.state_o), 32'd1);
    drive(busy_v); chk("lat3b busy1 ctl", 32'(ctl3), 32'(C_FREEZE)); chk("lat3b busy1 st", 32'(if3.state_o), 32'd1);
    drive(mis_v);  chk("lat3b b1 ctl", 32'(ctl3), 32'(C_STALL)); chk("lat3b b1 st", 32'(if3.state_o), 32'd1);
    drive(idle_v); chk("lat3b b2 ctl", 32'(ctl3), 32'(C_STALL)); chk("lat3b b2 st", 32'(if3.state_o), 32'd1);
    drive(idle_v); chk("lat3b done ctl", 32'(ctl3), 32'(C_DEF)); chk("lat3b done st", 32'(if3.state_o), 32'd0);
    drive(idle_v);
    chk("lat3b stall_cnt", if3.stall_cnt_o, 32'd8);
    chk("lat3b flush_cnt", if3.flush_cnt_o, 32'd0);

    // Reset in the middle of LDSTALL abandons the stall
    drive(lu3_v);
    drive(idle_v); chk("midrst pre st", 32'(if3.state_o), 32'd1);
    drive(rst_v);  chk("midrst ctl", 32'(ctl3), 32'(C_RST));
    drive(idle_v);
    chk("midrst rel ctl", 32'(ctl3), 32'(C_DEF));
    chk("midrst rel st", 32'(if3.state_o), 32'd0);
    chk("midrst stall_cnt", if3.stall_cnt_o, 32'd0);

    // Mispredict held across a 4-cycle memory freeze
    do_reset();
    for (int c = 0; c < 4; c++) begin
      drive(bm_v);
      chk($sformatf("memwait[%0d] ctl", c), 32'(ctl1), 32'(C_FREEZE));
      chk($sformatf("memwait[%0d] st", c), 32'(if1.state_o), (c == 0) ? 32'd0 : 32'd2);
    end
    drive(mis_v);
    chk("memwait exit ctl", 32'(ctl1), 32'(C_FLUSH));
    chk("memwait exit st", 32'(if1.state_o), 32'd2);
    drive(idle_v);
    chk("memwait after ctl", 32'(ctl1), 32'(C_DEF));
    chk("memwait after st", 32'(if1.state_o), 32'd0);
    chk("memwait stall_cnt", if1.stall_cnt_o, 32'd4);
    chk("memwait flush_cnt", if1.flush_cnt_o, 32'd1);

    // Counter saturation on the 4-bit instance
    do_reset();
    repeat (20) drive(busy_v);
    drive(idle_v);
    chk("sat stall_cnt", 32'(ifs.stall_cnt_o), 32'd15);
    chk("sat ref stall_cnt", if1.stall_cnt_o, 32'd20);
    repeat (3) drive(busy_v);
    drive(idle_v);
    chk("sat held stall_cnt", 32'(ifs.stall_cnt_o), 32'd15);
    chk("sat ref2 stall_cnt", if1.stall_cnt_o, 32'd23);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
